mem_bus_arbiter: RTL and testbench

- Shares the single word-wide memory port between two requesters: M0, instruction fetch, and M1, the data access issued by the MEM-stage memory controller.
- Round-robin arbitration on contention.
- Registers the granted address, write data and direction, and drives the memory strobe until the memory signals ready.
- Returns read data and a one-cycle acknowledge to the winner, with a timeout that aborts hung accesses.

---
 rtl/mem_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for a single word-wide memory port.
// The winning access is registered onto the strobed memory bus and completes with a one-cycle ack.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_rw,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rd_data,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_rw,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              err,
    output logic              busy,
    output logic              as_,
    output logic              rw,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rdy_
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              as_d, rw_d, err_d;
    logic              m0_ack_d, m1_ack_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wr_data_d, m0_rd_d, m1_rd_d;
    logic              last_q, last_d;   // 0: M0 won last, 1: M1 won last
    logic [7:0]        cnt_q, cnt_d;
    logic              elig0, elig1, pick1;

    // A requester whose ack is high this cycle is still showing the request it was just served for.
    assign elig0 = m0_req & ~m0_ack;
    assign elig1 = m1_req & ~m1_ack;
    assign pick1 = elig1 & (~elig0 | ~last_q);
    assign busy  = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        as_d      = as_;
        rw_d      = rw;
        addr_d    = addr;
        wr_data_d = wr_data;
        m0_ack_d  = 1'b0;
        m1_ack_d  = 1'b0;
        m0_rd_d   = m0_rd_data;
        m1_rd_d   = m1_rd_data;
        err_d     = 1'b0;
        last_d    = last_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (elig0 | elig1) begin
                    as_d  = 1'b0;
                    cnt_d = 8'd0;
                    if (pick1) begin
                        addr_d    = m1_addr;
                        rw_d      = m1_rw;
                        wr_data_d = m1_wr_data;
                        last_d    = 1'b1;
                        state_d   = ACC1;
                    end else begin
                        addr_d    = m0_addr;
                        rw_d      = m0_rw;
                        wr_data_d = m0_wr_data;
                        last_d    = 1'b0;
                        state_d   = ACC0;
                    end
                end
            end
            ACC0, ACC1: begin
                if (!rdy_ || cnt_q == LAST_WAIT) begin
                    // Ready wins over timeout when both land in the same cycle.
                    as_d    = 1'b1;
                    rw_d    = 1'b1;
                    err_d   = rdy_;
                    state_d = IDLE;
                    if (state_q == ACC1) begin
                        m1_ack_d = 1'b1;
                        m1_rd_d  = rdy_ ? '0 : rd_data;
                    end else begin
                        m0_ack_d = 1'b1;
                        m0_rd_d  = rdy_ ? '0 : rd_data;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                as_d    = 1'b1;
                rw_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            as_        <= 1'b1;
            rw         <= 1'b1;
            addr       <= '0;
            wr_data    <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rd_data <= '0;
            m1_rd_data <= '0;
            err        <= 1'b0;
            last_q     <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            as_        <= as_d;
            rw         <= rw_d;
            addr       <= addr_d;
            wr_data    <= wr_data_d;
            m0_ack     <= m0_ack_d;
            m1_ack     <= m1_ack_d;
            m0_rd_data <= m0_rd_d;
            m1_rd_data <= m1_rd_d;
            err        <= err_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by randomized two-master traffic
// checked against a transaction-level model of grants, wait times and completions.
module tb_mem_bus_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_rw, m0_ack, m1_req, m1_rw, m1_ack;
    logic [AW-1:0] m0_addr, m1_addr, addr;
    logic [DW-1:0] m0_wr_data, m0_rd_data, m1_wr_data, m1_rd_data;
    logic          err, busy, as_, rw, rdy_;
    logic [DW-1:0] wr_data, rd_data;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_rw(m0_rw), .m0_wr_data(m0_wr_data),
        .m0_ack(m0_ack), .m0_rd_data(m0_rd_data),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_rw(m1_rw), .m1_wr_data(m1_wr_data),
        .m1_ack(m1_ack), .m1_rd_data(m1_rd_data),
        .err(err), .busy(busy), .as_(as_), .rw(rw), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .rdy_(rdy_)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_addr = '0; m0_rw = 1'b1; m0_wr_data = '0;
        m1_req = 1'b0; m1_addr = '0; m1_rw = 1'b1; m1_wr_data = '0;
        rdy_ = 1'b1; rd_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    // Completion scoreboard: one entry per granted access.
    typedef struct {
        int            cycle;
        int            owner;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;
    exp_t exp_q[$];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] exp_addr[4];
        // random-phase model state
        int            t, win, a_s, a_w, a_last_low;
        bit            act, low, quiesce, e0, e1;
        int            last_win;
        logic [AW-1:0] a_addr;
        logic          a_rw;
        logic [DW-1:0] a_wd;
        logic          mreq[2], mrw[2];
        logic [AW-1:0] maddr[2];
        logic [DW-1:0] mwd[2], exp_rd[2];
        bit            stale[2], exp_ack[2];
        int            idle_cnt[2];
        logic          exp_err;
        exp_t          e;

        reset = 1'b1;
        idle_inputs();
        step();
        step();

        // Reset values, sampled with reset still asserted.
        chk1("rst_as", as_, 1'b1);
        chk1("rst_rw", rw, 1'b1);
        chka("rst_addr", addr, '0);
        chkd("rst_wr_data", wr_data, '0);
        chk1("rst_m0_ack", m0_ack, 1'b0);
        chk1("rst_m1_ack", m1_ack, 1'b0);
        chkd("rst_m0_rd", m0_rd_data, '0);
        chkd("rst_m1_rd", m1_rd_data, '0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_busy", busy, 1'b0);

        // Zero-wait M0 read.
        reset = 1'b0;
        m0_req = 1'b1; m0_addr = 30'h100; m0_rw = 1'b1;
        rdy_ = 1'b0; rd_data = 32'h1234_5678;
        step();
        chk1("t1_as", as_, 1'b0);
        chka("t1_addr", addr, 30'h100);
        chk1("t1_rw", rw, 1'b1);
        chk1("t1_busy", busy, 1'b1);
        chk1("t1_ack_early", m0_ack, 1'b0);
        step();
        chk1("t1_ack", m0_ack, 1'b1);
        chkd("t1_rd", m0_rd_data, 32'h1234_5678);
        chk1("t1_err", err, 1'b0);
        chk1("t1_as_rel", as_, 1'b1);
        chk1("t1_busy_rel", busy, 1'b0);
        m0_req = 1'b0; rdy_ = 1'b1;
        step();
        chk1("t1_ack_clr", m0_ack, 1'b0);
        chkd("t1_rd_hold", m0_rd_data, 32'h1234_5678);

        // M1 write with three wait cycles.
        m1_req = 1'b1; m1_addr = 30'h40; m1_rw = 1'b0; m1_wr_data = 32'hDEAD_BEEF;
        rd_data = 32'h0BAD_F00D;
        step();
        for (int k = 0; k < 4; k++) begin
            chk1("t2_as", as_, 1'b0);
            chk1("t2_rw", rw, 1'b0);
            chka("t2_addr", addr, 30'h40);
            chkd("t2_wr_data", wr_data, 32'hDEAD_BEEF);
            chk1("t2_ack_early", m1_ack, 1'b0);
            if (k == 3) begin
                rdy_ = 1'b0; rd_data = 32'h5A5A_0001;
            end
            step();
        end
        chk1("t2_ack", m1_ack, 1'b1);
        chk1("t2_m0_ack", m0_ack, 1'b0);
        chk1("t2_as_rel", as_, 1'b1);
        chk1("t2_err", err, 1'b0);
        chkd("t2_rd", m1_rd_data, 32'h5A5A_0001);
        m1_req = 1'b0; rdy_ = 1'b1;
        step();
        chk1("t2_ack_clr", m1_ack, 1'b0);

        // Simultaneous, continuously held requests alternate starting with M1.
        do_reset();
        m0_req = 1'b1; m0_addr = 30'h10; m0_rw = 1'b1;
        m1_req = 1'b1; m1_addr = 30'h20; m1_rw = 1'b1;
        rdy_ = 1'b0; rd_data = 32'h0000_0777;
        exp_addr[0] = 30'h20; exp_addr[1] = 30'h10; exp_addr[2] = 30'h20; exp_addr[3] = 30'h10;
        for (int g = 0; g < 4; g++) begin
            step();
            chk1("t3_as_low", as_, 1'b0);
            chka("t3_grant_addr", addr, exp_addr[g]);
            step();
            chk1("t3_as_high", as_, 1'b1);
            chk1("t3_m1_ack", m1_ack, (g % 2 == 0));
            chk1("t3_m0_ack", m0_ack, (g % 2 == 1));
        end
        m0_req = 1'b0; m1_req = 1'b0; rdy_ = 1'b1;
        step();
        chk1("t3_idle_as", as_, 1'b1);
        chk1("t3_idle_busy", busy, 1'b0);

        // M1 access that never sees ready is aborted after TO cycles.
        m1_req = 1'b1; m1_addr = 30'h3FF; m1_rw = 1'b1; rd_data = 32'hFFFF_0000;
        step();
        for (int k = 0; k < TO; k++) begin
            chk1("t4_as", as_, 1'b0);
            chk1("t4_ack_early", m1_ack, 1'b0);
            step();
        end
        chk1("t4_as_rel", as_, 1'b1);
        chk1("t4_ack", m1_ack, 1'b1);
        chk1("t4_err", err, 1'b1);
        chkd("t4_rd", m1_rd_data, '0);
        chk1("t4_busy", busy, 1'b0);
        m1_req = 1'b0;
        step();
        chk1("t4_err_clr", err, 1'b0);
        chk1("t4_ack_clr", m1_ack, 1'b0);

        // Reset on the second wait cycle abandons the access; a fresh request then completes.
        m0_req = 1'b1; m0_addr = 30'h55; m0_rw = 1'b1;
        step();
        chk1("t5_as_w1", as_, 1'b0);
        step();
        chk1("t5_as_w2", as_, 1'b0);
        reset = 1'b1; m0_req = 1'b0;
        step();
        chk1("t5_as_rst", as_, 1'b1);
        chk1("t5_busy_rst", busy, 1'b0);
        chk1("t5_no_ack", m0_ack, 1'b0);
        reset = 1'b0;
        step();
        chk1("t5_no_ack2", m0_ack, 1'b0);
        chk1("t5_as_idle", as_, 1'b1);
        m0_req = 1'b1; m0_addr = 30'h66; rdy_ = 1'b0; rd_data = 32'hA5A5_A5A5;
        step();
        chk1("t5_as_fresh", as_, 1'b0);
        chka("t5_addr_fresh", addr, 30'h66);
        step();
        chk1("t5_ack_fresh", m0_ack, 1'b1);
        chkd("t5_rd_fresh", m0_rd_data, 32'hA5A5_A5A5);
        chk1("t5_err_fresh", err, 1'b0);

        // M0 keeps its request high during the ack cycle: no second grant.
        step();
        chk1("t6_as_stale", as_, 1'b1);
        chk1("t6_busy_stale", busy, 1'b0);
        chk1("t6_ack_clr", m0_ack, 1'b0);
        m0_req = 1'b0;
        step();
        chk1("t6_as_after", as_, 1'b1);
        rdy_ = 1'b1;

        // Randomized traffic against the transaction-level model.
        do_reset();
        step();
        t = 0; act = 0; quiesce = 0; last_win = 0;
        a_s = 0; a_w = 0; a_last_low = -1; a_addr = '0; a_rw = 1'b1; a_wd = '0;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            mreq[i] = 1'b0; mrw[i] = 1'b1; maddr[i] = '0; mwd[i] = '0;
            exp_rd[i] = '0; stale[i] = 0; idle_cnt[i] = 0;
        end
        for (int cyc = 0; cyc < 2200; cyc++) begin
            if (cyc == 2100) quiesce = 1;
            low = act && t >= a_s && t <= a_last_low;
            chk1("r_as", as_, !low);
            chk1("r_busy", busy, low);
            if (low) begin
                chka("r_addr", addr, a_addr);
                chk1("r_rw", rw, a_rw);
                chkd("r_wr_data", wr_data, a_wd);
            end else begin
                chk1("r_rw_idle", rw, 1'b1);
            end
            exp_ack[0] = 0; exp_ack[1] = 0; exp_err = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].cycle == t) begin
                e = exp_q.pop_front();
                exp_ack[e.owner] = 1;
                exp_err = e.err;
                exp_rd[e.owner] = e.data;
                act = 0;
            end
            chk1("r_m0_ack", m0_ack, exp_ack[0]);
            chk1("r_m1_ack", m1_ack, exp_ack[1]);
            chk1("r_err", err, exp_err);
            chkd("r_m0_rd", m0_rd_data, exp_rd[0]);
            chkd("r_m1_rd", m1_rd_data, exp_rd[1]);

            // Masters
            for (int i = 0; i < 2; i++) begin
                if (exp_ack[i]) begin
                    stale[i] = ($urandom_range(0, 2) == 0);
                    if (!stale[i]) mreq[i] = 1'b0;
                    idle_cnt[i] = int'($urandom_range(0, 3));
                end else if (stale[i]) begin
                    mreq[i] = 1'b0;
                    stale[i] = 0;
                end else if (mreq[i]) begin
                    if (!(act && win == i) && $urandom_range(0, 7) == 0) mreq[i] = 1'b0;
                end else if (!quiesce) begin
                    if (idle_cnt[i] > 0) idle_cnt[i]--;
                    else if ($urandom_range(0, 1) == 1) begin
                        mreq[i] = 1'b1;
                        maddr[i] = AW'($urandom);
                        mrw[i] = 1'($urandom_range(0, 1));
                        mwd[i] = $urandom;
                    end
                end
            end
            m0_req = mreq[0]; m0_addr = maddr[0]; m0_rw = mrw[0]; m0_wr_data = mwd[0];
            m1_req = mreq[1]; m1_addr = maddr[1]; m1_rw = mrw[1]; m1_wr_data = mwd[1];

            // Memory: answers in the cycle chosen at grant time, random noise otherwise.
            if (low) begin
                if (a_w < TO && t == a_s + a_w) begin
                    rdy_ = 1'b0; rd_data = exp_q[0].data;
                end else begin
                    rdy_ = 1'b1; rd_data = $urandom;
                end
            end else begin
                rdy_ = 1'($urandom_range(0, 1)); rd_data = $urandom;
            end

            // Arbitration at the coming edge.
            if (!act) begin
                e0 = mreq[0] && !exp_ack[0];
                e1 = mreq[1] && !exp_ack[1];
                if (e0 || e1) begin
                    win = (e0 && e1) ? 1 - last_win : (e1 ? 1 : 0);
                    last_win = win;
                    act = 1;
                    a_addr = maddr[win]; a_rw = mrw[win]; a_wd = mwd[win];
                    a_s = t + 1;
                    if ($urandom_range(0, 3) == 0) a_w = int'($urandom_range(0, TO + 3));
                    else a_w = int'($urandom_range(0, 2));
                    e.owner = win;
                    if (a_w < TO) begin
                        a_last_low = a_s + a_w;
                        e.cycle = a_s + a_w + 1; e.data = $urandom; e.err = 1'b0;
                    end else begin
                        a_last_low = a_s + TO - 1;
                        e.cycle = a_s + TO; e.data = '0; e.err = 1'b1;
                    end
                    exp_q.push_back(e);
                end
            end
            step();
            t++;
        end
        n_chk++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL r_drain: observed %0d pending completions expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
